// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM: host write/read bursts become RAM cycles.
// Latency: write beat hits RAM same cycle; read beat appears 2 cycles after issue.
// Backpressure: wr_ready only in WRITE; reads throttled to 2 outstanding against rd_ready.
module ram_burst_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [AW-1:0]    cmd_len,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             ram_cs_n,
    output logic             ram_we_n,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE       = AW'(1);

    state_t           state, state_nxt;
    logic [AW-1:0]    cur_addr, remaining, next_addr;
    logic             in_flight;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             fifo_wp, fifo_rp;
    logic [1:0]       fifo_cnt;
    logic             pop, wr_acc, rd_issue;
    logic [2:0]       occupancy, issue_limit;

    assign rd_valid    = (fifo_cnt != 2'd0);
    assign rd_data     = fifo_mem[fifo_rp];
    assign pop         = rd_valid & rd_ready;
    assign busy        = (state != IDLE);
    assign ram_addr    = cur_addr;
    assign ram_din     = wr_data;
    assign next_addr   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ONE;
    // A beat leaving this cycle frees a slot, so issuing alongside a pop keeps 1 beat/cycle.
    assign occupancy   = {1'b0, fifo_cnt} + {2'b00, in_flight};
    assign issue_limit = 3'd2 + {2'b00, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_cs_n  = 1'b1;
        ram_we_n  = 1'b1;
        wr_acc    = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wr_acc   = 1'b1;
                    ram_cs_n = 1'b0;
                    ram_we_n = 1'b0;
                    if (remaining == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                if (occupancy < issue_limit) begin
                    rd_issue = 1'b1;
                    ram_cs_n = 1'b0;
                    if (remaining == '0) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0 && !in_flight) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_acc || rd_issue) begin
                cur_addr  <= next_addr;
                remaining <= remaining - ONE;
            end
            in_flight <= rd_issue;
            if (in_flight) begin
                fifo_wp <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    // RAM read data is valid the cycle after issue; capture it then.
    always_ff @(posedge clk) begin
        if (in_flight) begin
            fifo_mem[fifo_wp] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural RAM plus a word-array reference of memory contents.
module tb_ram_burst_master;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]    cmd_addr, cmd_len;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid, wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, rd_ready;
    logic             busy, ram_cs_n, ram_we_n;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ram_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural single-port RAM with registered read data.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_addr] <= ram_din;
            else           ram_dout <= mem[ram_addr];
        end
    end

    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] wdat [DEPTH];
    int total = 0;
    int passed = 0;
    int cyc = 0;

    logic [AW-1:0]    wlog_a [$];
    logic [WIDTH-1:0] wlog_d [$];
    logic [AW-1:0]    rlog_a [$];
    logic [WIDTH-1:0] rdq [$];
    int               rdcyc [$];
    int               iss, pops;
    bit               prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: records RAM cycles and read handshakes mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            iss = 0;
            pops = 0;
            prev_stall = 0;
        end else begin
            if (!ram_cs_n && !ram_we_n) begin
                wlog_a.push_back(ram_addr);
                wlog_d.push_back(ram_din);
                chk("wr_only_on_beat", {31'b0, wr_valid && wr_ready}, 1);
            end
            if (!ram_cs_n && ram_we_n) begin
                rlog_a.push_back(ram_addr);
                chk("outstanding_le2", {31'b0, (iss + 1 - pops - int'(rd_valid && rd_ready)) > 2}, 0);
                iss++;
            end
            if (prev_stall) begin
                chk("stall_valid", {31'b0, rd_valid}, 1);
                chk("stall_data", {24'b0, rd_data}, {24'b0, prev_data});
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rd_valid && rd_ready) begin
                rdq.push_back(rd_data);
                rdcyc.push_back(cyc);
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete(); rdq.delete(); rdcyc.delete();
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        bit acc;
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        do begin
            #1 acc = cmd_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("cmd_accept_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode, input bit hold);
        bit acc;
        int i = 0;
        int n = 0;
        clear_logs();
        send_cmd(1, a, l);
        if (hold) begin
            cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
        end
        while (i <= int'(l) && n < 100) begin
            wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            wr_data  = wdat[i];
            #1 acc = wr_valid && wr_ready;
            if (hold) chk("held_cmd_rdy", {31'b0, cmd_ready}, 0);
            tick();
            if (acc) i++;
            n++;
        end
        wr_valid = 0;
        if (i <= int'(l)) chk("wr_timeout", 0, 1);
        chk("wr_idle_after", {31'b0, busy}, 0);
        chk("wr_count", wlog_a.size(), int'(l) + 1);
        for (int k = 0; k < wlog_a.size() && k <= int'(l); k++) begin
            chk("wr_addr", {29'b0, wlog_a[k]}, (int'(a) + k) % DEPTH);
            chk("wr_data", {24'b0, wlog_d[k]}, {24'b0, wdat[k]});
        end
        for (int k = 0; k <= int'(l); k++) ref_mem[(int'(a) + k) % DEPTH] = wdat[k];
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode,
                           input bit b2b, input bit held);
        int n = 0;
        rd_ready = 1;
        clear_logs();
        if (held) begin
            #1 chk("held_cmd_idle_rdy", {31'b0, cmd_ready}, 1);
            tick();
            cmd_valid = 0;
        end else begin
            send_cmd(0, a, l);
        end
        while (busy && n < 300) begin
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 1) : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        rd_ready = 0;
        if (busy) chk("rd_timeout", 0, 1);
        chk("rd_count", rdq.size(), int'(l) + 1);
        chk("rd_issue_count", rlog_a.size(), int'(l) + 1);
        for (int k = 0; k < rdq.size() && k <= int'(l); k++)
            chk("rd_data", {24'b0, rdq[k]}, {24'b0, ref_mem[(int'(a) + k) % DEPTH]});
        for (int k = 0; k < rlog_a.size() && k <= int'(l); k++)
            chk("rd_ram_addr", {29'b0, rlog_a[k]}, (int'(a) + k) % DEPTH);
        if (b2b)
            for (int k = 1; k < rdcyc.size(); k++)
                chk("rd_b2b_gap", rdcyc[k] - rdcyc[k-1], 1);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        tick(); tick();
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_cs_n", {31'b0, ram_cs_n}, 1);
        chk("rst_we_n", {31'b0, ram_we_n}, 1);
        chk("rst_addr", {29'b0, ram_addr}, 0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        reset = 0;
        tick();

        // Basic write then back-to-back readback
        wdat[0] = 8'd5; wdat[1] = 8'd12; wdat[2] = 8'd36;
        do_write(3'd1, 3'd2, 0, 0);
        do_read(3'd1, 3'd2, 0, 1, 0);

        // Address wrap inside a burst
        for (int k = 0; k < 4; k++) wdat[k] = 8'hA1 + 8'(k);
        do_write(3'd6, 3'd3, 0, 0);
        do_read(3'd6, 3'd3, 0, 1, 0);

        // Full-depth read with stalled consumer
        do_read(3'd0, 3'd7, 1, 0, 0);

        // Gappy write stream
        for (int k = 0; k < 4; k++) wdat[k] = 8'h30 + 8'(k);
        do_write(3'd2, 3'd3, 1, 0);
        do_read(3'd2, 3'd3, 0, 1, 0);

        // Command held off during a write, then accepted in the first idle cycle
        for (int k = 0; k < 3; k++) wdat[k] = 8'(k * 17 + 9);
        do_write(3'd3, 3'd2, 0, 1);
        do_read(3'd3, 3'd2, 0, 1, 1);

        // Randomized mix of bursts
        for (int r = 0; r < 12; r++) begin
            logic [AW-1:0] ra, rl;
            ra = AW'($urandom_range(0, DEPTH - 1));
            rl = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < DEPTH; k++) wdat[k] = 8'($urandom);
                do_write(ra, rl, 2, 0);
            end else begin
                do_read(ra, rl, 2, 0, 0);
            end
        end

        // Reset at the third read beat aborts the burst immediately
        begin
            int n = 0;
            bit hit = 0;
            rd_ready = 1;
            clear_logs();
            send_cmd(0, 3'd0, 3'd7);
            while (n < 50 && !hit) begin
                #1;
                if (rd_valid && rdq.size() == 2) hit = 1;
                else begin tick(); n++; end
            end
            if (!hit) chk("rst_mid_timeout", 0, 1);
            reset = 1;
            #1;
            chk("rst_mid_rd_valid", {31'b0, rd_valid}, 0);
            chk("rst_mid_cs_n", {31'b0, ram_cs_n}, 1);
            chk("rst_mid_busy", {31'b0, busy}, 0);
            chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 1);
            rd_ready = 0;
            tick(); tick();
            reset = 0;
            tick();
            wdat[0] = 8'h55;
            do_write(3'd0, 3'd0, 0, 0);
            do_read(3'd0, 3'd0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
